enc_serial: RTL and testbench



---
 rtl/enc_pkg.sv | 18 +
 rtl/enc_lsb_find.sv | 38 +++
 rtl/enc_serial.sv | 130 +++++++++++++
 tb/tb_enc_serial.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
//   Shared types and helpers for the bitmap-to-index serializer.
//   - state_t : serializer FSM state
//   - enc_w() : index width for an N-bit request vector ($clog2(N), min 1)
// ---------------------------------------------------------------------------
package enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int enc_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/enc_lsb_find.sv
// ---------------------------------------------------------------------------
// enc_lsb_find
//   Combinational lowest-set-bit finder.
//   Ports:
//     vector [N]  in   bitmap to search
//     idx    [W]  out  index of the lowest set bit (0 when vector is empty)
//     onehot [N]  out  one-hot mask of the lowest set bit (0 when empty)
//     multi        out  more than one bit of vector is set
// ---------------------------------------------------------------------------
module enc_lsb_find
    import enc_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = enc_w(N)
) (
    input  logic [N-1:0] vector,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         multi
);

    // Scan from the top down so the last hit (lowest index) wins.
    always_comb begin
        idx    = '0;
        onehot = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (vector[k]) begin
                idx       = W'(k);
                onehot    = '0;
                onehot[k] = 1'b1;
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(vector & (vector - N'(1)));

endmodule

// File: rtl/enc_serial.sv
// ---------------------------------------------------------------------------
// enc_serial
//   Bitmap-to-index serializer. Accepts an N-bit request vector and emits the
//   index of every set bit, LSB first, one beat per cycle. The final beat of
//   each vector is flagged with o_last; an all-zero vector yields a single
//   beat with o_none=1, o_out=0.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no vector held; ready for a new one
//   BUSY  | pending holds the not-yet-emitted bits; a beat is on o_out
//
//   Ports:
//     i_clk   in        clock, rising edge
//     i_rst   in        asynchronous active-high reset
//     i_in    in  [N]   request vector, sampled only on accept
//     i_en    in        input valid
//     o_rdy   out       input ready (accept = i_en & o_rdy)
//     o_out   out [W]   index of the current beat
//     o_vld   out       output valid
//     i_rdy   in        downstream ready (consume = o_vld & i_rdy)
//     o_last  out       current beat is the vector's final beat
//     o_none  out       current beat stands for an all-zero vector
// ---------------------------------------------------------------------------
module enc_serial
    import enc_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = enc_w(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_in,
    input  logic         i_en,
    output logic         o_rdy,
    output logic [W-1:0] o_out,
    output logic         o_vld,
    input  logic         i_rdy,
    output logic         o_last,
    output logic         o_none
);

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   pending_q;
    logic [W-1:0]   lsb_idx;
    logic [N-1:0]   lsb_onehot;
    logic           lsb_multi;
    logic           accept;
    logic           consume;

    enc_lsb_find #(.N(N)) u_lsb (
        .vector (pending_q),
        .idx    (lsb_idx),
        .onehot (lsb_onehot),
        .multi  (lsb_multi)
    );

    assign accept  = i_en & o_rdy;
    assign consume = o_vld & i_rdy;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A new vector can be taken in the same cycle the last beat
                // leaves, so back-to-back vectors have no bubble.
                if (consume && o_last) begin
                    state_d = accept ? BUSY : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending bitmap: loaded on accept, lowest bit stripped on each consume.
    // On the final consume this leaves zero, which is harmless in IDLE since
    // every output is gated by BUSY.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending_q <= '0;
        end else if (accept) begin
            pending_q <= i_in;
        end else if (consume) begin
            pending_q <= pending_q & ~lsb_onehot;
        end
    end

    // Output logic. o_rdy is the only combinational path from an input
    // (i_rdy); it is also held low during reset so nothing is accepted
    // while the FSM is being forced to IDLE.
    always_comb begin
        o_vld  = 1'b0;
        o_out  = '0;
        o_last = 1'b0;
        o_none = 1'b0;
        o_rdy  = 1'b0;
        case (state_q)
            IDLE: begin
                o_rdy = ~i_rst;
            end
            BUSY: begin
                o_vld  = 1'b1;
                o_out  = lsb_idx;
                o_last = ~lsb_multi;
                o_none = ~|pending_q;
                o_rdy  = ~i_rst & i_rdy & ~lsb_multi;
            end
            default: begin
                o_rdy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_enc_serial.sv
module tb_enc_serial;

    localparam int N = 4;
    localparam int W = 2;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic [N-1:0] i_in  = '0;
    logic         i_en  = 1'b0;
    logic         o_rdy;
    logic [W-1:0] o_out;
    logic         o_vld;
    logic         i_rdy = 1'b0;
    logic         o_last;
    logic         o_none;

    enc_serial #(.N(N)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_in   (i_in),
        .i_en   (i_en),
        .o_rdy  (o_rdy),
        .o_out  (o_out),
        .o_vld  (o_vld),
        .i_rdy  (i_rdy),
        .o_last (o_last),
        .o_none (o_none)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a vector turns into a list of beats (index, last, none)
    typedef struct {
        int unsigned idx;
        bit          last;
        bit          none;
    } beat_t;

    beat_t sb[$];
    bit          hold_armed = 1'b0;
    int unsigned held_out;
    int unsigned held_last;
    int unsigned held_none;

    function automatic void push_vector(input logic [N-1:0] v);
        beat_t b;
        int    first = sb.size();
        for (int k = 0; k < N; k++) begin
            if (v[k]) begin
                b.idx = k; b.last = 0; b.none = 0;
                sb.push_back(b);
            end
        end
        if (sb.size() == first) begin
            b.idx = 0; b.last = 1; b.none = 1;
            sb.push_back(b);
        end else begin
            sb[sb.size()-1].last = 1;
        end
    endfunction

    always @(posedge i_rst) begin
        sb.delete();
        hold_armed = 1'b0;
    end

    always @(posedge i_clk) begin
        if (i_rst) begin
            hold_armed = 1'b0;
        end else begin
            beat_t e;
            chk("sb_vld", o_vld, (sb.size() != 0) ? 1 : 0);
            if (hold_armed) begin
                chk("hold_out",  o_out,  held_out);
                chk("hold_last", o_last, held_last);
                chk("hold_none", o_none, held_none);
            end
            hold_armed = o_vld && !i_rdy;
            held_out   = o_out;
            held_last  = o_last;
            held_none  = o_none;
            if (o_vld && i_rdy) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_idx",  o_out,  e.idx);
                    chk("sb_last", o_last, e.last);
                    chk("sb_none", o_none, e.none);
                end
            end
            if (i_en && o_rdy) push_vector(i_in);
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #2;
    endtask

    task automatic beat(input string tag, input bit vld, input int unsigned out,
                        input bit last, input bit none);
        chk({tag, "_vld"},  o_vld,  vld);
        chk({tag, "_out"},  o_out,  out);
        chk({tag, "_last"}, o_last, last);
        chk({tag, "_none"}, o_none, none);
    endtask

    int vec_n;
    int cycles;
    bit acc;

    initial begin
        // 1: reset asserted mid-cycle
        #1 i_rst = 1'b1;
        #1;
        chk("rst_vld", o_vld, 0);
        chk("rst_out", o_out, 0);
        chk("rst_rdy", o_rdy, 0);
        tick; tick;
        i_rst = 1'b0;
        #1;
        chk("rel_rdy", o_rdy, 1);
        beat("rel", 0, 0, 0, 0);

        // 2: 1011 -> 0,1,3
        i_in = 4'b1011; i_en = 1'b1; i_rdy = 1'b1;
        tick;
        i_en = 1'b0; i_in = 4'b0100;
        #1 beat("t2b0", 1, 0, 0, 0); chk("t2b0_rdy", o_rdy, 0);
        tick;
        #1 beat("t2b1", 1, 1, 0, 0); chk("t2b1_rdy", o_rdy, 0);
        tick;
        #1 beat("t2b2", 1, 3, 1, 0); chk("t2b2_rdy", o_rdy, 1);
        tick;
        #1 beat("t2end", 0, 0, 0, 0);

        // 3: zero vector
        i_in = 4'b0000; i_en = 1'b1;
        tick;
        i_en = 1'b0;
        #1 beat("t3b0", 1, 0, 1, 1);
        tick;
        #1 beat("t3end", 0, 0, 0, 0); chk("t3_rdy", o_rdy, 1);

        // 4: 0110 with three stalled cycles
        i_in = 4'b0110; i_en = 1'b1; i_rdy = 1'b0;
        tick;
        i_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 beat("t4stall", 1, 1, 0, 0); chk("t4stall_rdy", o_rdy, 0);
            tick;
        end
        i_rdy = 1'b1;
        #1 beat("t4b0", 1, 1, 0, 0);
        tick;
        #1 beat("t4b1", 1, 2, 1, 0);
        tick;
        #1 beat("t4end", 0, 0, 0, 0);

        // 5: back-to-back 1000 then 0001
        i_in = 4'b1000; i_en = 1'b1;
        tick;
        i_in = 4'b0001;
        #1 beat("t5b0", 1, 3, 1, 0); chk("t5b0_rdy", o_rdy, 1);
        tick;
        i_en = 1'b0;
        #1 beat("t5b1", 1, 0, 1, 0);
        tick;
        #1 beat("t5end", 0, 0, 0, 0);

        // 6: 1111 with reset after the first beat
        i_in = 4'b1111; i_en = 1'b1;
        tick;
        i_en = 1'b0;
        #1 beat("t6b0", 1, 0, 0, 0);
        tick;
        #1 i_rst = 1'b1;
        #1;
        chk("t6rst_vld", o_vld, 0);
        chk("t6rst_out", o_out, 0);
        chk("t6rst_rdy", o_rdy, 0);
        tick;
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t6quiet_vld", o_vld, 0);
            tick;
        end

        // Random vectors with random downstream backpressure
        vec_n  = 0;
        cycles = 0;
        i_en   = 1'b0;
        while (vec_n < 200 && cycles < 20000) begin
            if (!i_en && $urandom_range(0, 3) != 0) begin
                i_in = N'($urandom);
                i_en = 1'b1;
            end else if (!i_en) begin
                i_in = N'($urandom);
            end
            i_rdy = ($urandom_range(0, 3) != 0);
            #1;
            acc = i_en && o_rdy;
            tick;
            cycles++;
            if (acc) begin
                vec_n++;
                i_en = 1'b0;
            end
        end
        chk("rand_vectors", vec_n, 200);

        i_en  = 1'b0;
        i_rdy = 1'b1;
        for (int i = 0; i < 20 && o_vld; i++) tick;
        #1;
        chk("drain_vld", o_vld, 0);
        chk("drain_sb", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
